// File: rtl/cronometro_pkg.sv
// Shared types and stage moduli for the stopwatch control unit.
package cronometro_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAP_HOLD,
        PAUSE
    } state_t;

    localparam int CS_MOD  = 100;
    localparam int SEC_MOD = 60;

endpackage

// File: rtl/control_cronometro_if.sv
// Button pulses in, live/display counts and status out.
interface control_cronometro_if #(
    parameter int MAX_MIN = 60
);
    localparam int MW = $clog2(MAX_MIN);

    logic          START_STOP;
    logic          CLEAR;
    logic          LAP;
    logic [6:0]    CS;
    logic [5:0]    SEC;
    logic [MW-1:0] MIN;
    logic [6:0]    D_CS;
    logic [5:0]    D_SEC;
    logic [MW-1:0] D_MIN;
    logic          RUNNING;
    logic          LAP_ACTIVE;
    logic          OVF;

    modport master (
        output START_STOP, CLEAR, LAP,
        input  CS, SEC, MIN, D_CS, D_SEC, D_MIN,
        input  RUNNING, LAP_ACTIVE, OVF
    );

    modport slave (
        input  START_STOP, CLEAR, LAP,
        output CS, SEC, MIN, D_CS, D_SEC, D_MIN,
        output RUNNING, LAP_ACTIVE, OVF
    );

endinterface

// File: rtl/cronometro_etapa.sv
// Modulo-M up-counter stage with sync clear and same-cycle carry out.
module cronometro_etapa #(
    parameter  int M = 10,
    localparam int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         CLR,
    input  logic         EN,
    output logic [W-1:0] COUNT,
    output logic         CARRY
);

    localparam logic [W-1:0] TOP = W'(M - 1);

    assign CARRY = EN && (COUNT == TOP);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            COUNT <= '0;
        end else if (CLR) begin
            COUNT <= '0;
        end else if (EN) begin
            COUNT <= CARRY ? '0 : COUNT + 1'b1;
        end
    end

endmodule

// File: rtl/control_cronometro.sv
// Stopwatch control: run/pause/lap FSM, prescaler and cs/sec/min chain.
module control_cronometro
    import cronometro_pkg::*;
#(
    parameter int DIV     = 500000,
    parameter int MAX_MIN = 60
) (
    input logic                 CLK,
    input logic                 RSTn,
    control_cronometro_if.slave bus
);

    localparam int MW = $clog2(MAX_MIN);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    state_t state_q;
    state_t state_d;

    logic          ss;
    logic          clr;
    logic          lap;
    logic          capture;
    logic          zero;
    logic          en;
    logic          tick;
    logic          cs_carry;
    logic          sec_carry;
    logic          ovf;
    logic [PW-1:0] pre_unused;
    logic [6:0]    cs_q;
    logic [5:0]    sec_q;
    logic [MW-1:0] min_q;
    logic [6:0]    lap_cs;
    logic [5:0]    lap_sec;
    logic [MW-1:0] lap_min;

    // Strict priority: only the highest pending pulse is seen
    assign ss  = bus.START_STOP;
    assign clr = bus.CLEAR & ~ss;
    assign lap = bus.LAP & ~bus.CLEAR & ~ss;

    assign en = (state_q == RUN) || (state_q == LAP_HOLD);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        zero    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ss) state_d = RUN;
            end
            RUN: begin
                unique case (1'b1)
                    ss:  state_d = PAUSE;
                    lap: begin
                        state_d = LAP_HOLD;
                        capture = 1'b1;
                    end
                    default: ;
                endcase
            end
            LAP_HOLD: begin
                unique case (1'b1)
                    ss:      state_d = PAUSE;
                    lap:     state_d = RUN;
                    default: ;
                endcase
            end
            PAUSE: begin
                unique case (1'b1)
                    ss:  state_d = RUN;
                    clr: begin
                        state_d = IDLE;
                        zero    = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    cronometro_etapa #(.M(DIV)) u_pre (
        .CLK(CLK), .RSTn(RSTn), .CLR(zero), .EN(en),
        .COUNT(pre_unused), .CARRY(tick)
    );

    cronometro_etapa #(.M(CS_MOD)) u_cs (
        .CLK(CLK), .RSTn(RSTn), .CLR(zero), .EN(tick),
        .COUNT(cs_q), .CARRY(cs_carry)
    );

    cronometro_etapa #(.M(SEC_MOD)) u_sec (
        .CLK(CLK), .RSTn(RSTn), .CLR(zero), .EN(cs_carry),
        .COUNT(sec_q), .CARRY(sec_carry)
    );

    cronometro_etapa #(.M(MAX_MIN)) u_min (
        .CLK(CLK), .RSTn(RSTn), .CLR(zero), .EN(sec_carry),
        .COUNT(min_q), .CARRY(ovf)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            lap_cs  <= '0;
            lap_sec <= '0;
            lap_min <= '0;
        end else if (capture) begin
            lap_cs  <= cs_q;
            lap_sec <= sec_q;
            lap_min <= min_q;
        end
    end

    assign bus.CS         = cs_q;
    assign bus.SEC        = sec_q;
    assign bus.MIN        = min_q;
    assign bus.D_CS       = (state_q == LAP_HOLD) ? lap_cs  : cs_q;
    assign bus.D_SEC      = (state_q == LAP_HOLD) ? lap_sec : sec_q;
    assign bus.D_MIN      = (state_q == LAP_HOLD) ? lap_min : min_q;
    assign bus.RUNNING    = en;
    assign bus.LAP_ACTIVE = (state_q == LAP_HOLD);
    assign bus.OVF        = ovf;

endmodule

// File: tb/tb_control_cronometro.sv
// Bench: vector table, random run against a total-centisecond model, wrap test.
module tb_control_cronometro;

    localparam int LIM4 = 100 * 60 * 60;

    logic CLK = 1'b0;
    logic RSTn;

    always #5 CLK = ~CLK;

    control_cronometro_if #(.MAX_MIN(60)) b4 ();
    control_cronometro_if #(.MAX_MIN(2))  b1 ();

    control_cronometro #(.DIV(4), .MAX_MIN(60)) u4 (
        .CLK(CLK), .RSTn(RSTn), .bus(b4)
    );

    control_cronometro #(.DIV(1), .MAX_MIN(2)) u1 (
        .CLK(CLK), .RSTn(RSTn), .bus(b1)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 run, 2 lap, 3 pause; time as total centiseconds
    int ms, pre, tot, lap_tot;

    typedef struct {
        bit ss;
        bit cl;
        bit lp;
        int n;
        bit run;
        bit lapa;
        int cs;
        int dcs;
        int sec;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic mreset();
        ms = 0; pre = 0; tot = 0; lap_tot = 0;
    endtask

    task automatic mstep(input bit s, input bit c, input bit l);
        int old = tot;
        int nx = ms;
        if (ms == 1 || ms == 2) begin
            if (pre == 3) begin
                pre = 0;
                tot = (tot + 1) % LIM4;
            end else begin
                pre++;
            end
        end
        case (ms)
            0: if (s) nx = 1;
            1: begin
                if (s) nx = 3;
                else if (!c && l) begin
                    nx = 2;
                    lap_tot = old;
                end
            end
            2: begin
                if (s) nx = 3;
                else if (!c && l) nx = 1;
            end
            default: begin
                if (s) nx = 1;
                else if (c) begin
                    nx = 0; pre = 0; tot = 0;
                end
            end
        endcase
        ms = nx;
    endtask

    task automatic cyc4(input bit s, input bit c, input bit l);
        b4.START_STOP = s; b4.CLEAR = c; b4.LAP = l;
        @(posedge CLK);
        mstep(s, c, l);
        #1;
        b4.START_STOP = 0; b4.CLEAR = 0; b4.LAP = 0;
    endtask

    task automatic cyc1(input bit s);
        b1.START_STOP = s;
        @(posedge CLK);
        #1;
        b1.START_STOP = 0;
    endtask

    task automatic check_model();
        int dt;
        bit run, ovf;
        logic [63:0] got, exp;
        dt  = (ms == 2) ? lap_tot : tot;
        run = (ms == 1 || ms == 2);
        ovf = run && pre == 3 && tot == LIM4 - 1;
        got = {b4.CS, b4.SEC, b4.MIN, b4.D_CS, b4.D_SEC, b4.D_MIN,
               b4.RUNNING, b4.LAP_ACTIVE, b4.OVF};
        exp = {7'(tot % 100), 6'((tot / 100) % 60), 6'(tot / 6000),
               7'(dt % 100), 6'((dt / 100) % 60), 6'(dt / 6000),
               run, (ms == 2), ovf};
        chk("model", got, exp);
    endtask

    initial begin
        // ss cl lp  n   run lapa cs dcs sec
        tbl[0]  = '{1, 0, 0, 1,   1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 3,   1, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 1,   1, 0, 1, 1, 0};
        tbl[3]  = '{0, 0, 1, 1,   1, 1, 1, 1, 0};
        tbl[4]  = '{0, 0, 0, 8,   1, 1, 3, 1, 0};
        tbl[5]  = '{1, 0, 1, 1,   0, 0, 3, 3, 0};
        tbl[6]  = '{0, 0, 0, 50,  0, 0, 3, 3, 0};
        tbl[7]  = '{1, 1, 0, 1,   1, 0, 3, 3, 0};
        tbl[8]  = '{0, 0, 0, 2,   1, 0, 4, 4, 0};
        tbl[9]  = '{1, 0, 0, 1,   0, 0, 4, 4, 0};
        tbl[10] = '{0, 1, 1, 1,   0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 1, 1,   0, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 1,   0, 0, 0, 0, 0};
        tbl[13] = '{1, 0, 0, 5,   1, 0, 1, 1, 0};
        tbl[14] = '{1, 0, 1, 1,   0, 0, 1, 1, 0};
        tbl[15] = '{0, 1, 0, 1,   0, 0, 0, 0, 0};
        tbl[16] = '{1, 0, 0, 1,   1, 0, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 400, 1, 0, 0, 0, 1};

        RSTn = 1'b0;
        b4.START_STOP = 0; b4.CLEAR = 0; b4.LAP = 0;
        b1.START_STOP = 0; b1.CLEAR = 0; b1.LAP = 0;
        mreset();
        #12;
        chk("reset_cs", b4.CS, 0);
        chk("reset_running", b4.RUNNING, 0);
        chk("reset_lap", b4.LAP_ACTIVE, 0);
        chk("reset_ovf", b4.OVF, 0);
        chk("reset_dcs", b4.D_CS, 0);
        RSTn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cyc4(tbl[i].ss, tbl[i].cl, tbl[i].lp);
            for (int k = 1; k < tbl[i].n; k++) cyc4(0, 0, 0);
            chk($sformatf("vec%0d_running", i), b4.RUNNING, tbl[i].run);
            chk($sformatf("vec%0d_lap", i), b4.LAP_ACTIVE, tbl[i].lapa);
            chk($sformatf("vec%0d_cs", i), b4.CS, tbl[i].cs);
            chk($sformatf("vec%0d_dcs", i), b4.D_CS, tbl[i].dcs);
            chk($sformatf("vec%0d_sec", i), b4.SEC, tbl[i].sec);
        end

        // Asynchronous reset mid-count, away from any clock edge
        repeat (6) cyc4(0, 0, 0);
        chk("pre_areset_cs", b4.CS, 1);
        chk("pre_areset_sec", b4.SEC, 1);
        #3;
        RSTn = 1'b0;
        #1;
        chk("areset_cs", b4.CS, 0);
        chk("areset_sec", b4.SEC, 0);
        chk("areset_running", b4.RUNNING, 0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        mreset();
        cyc4(0, 0, 0);
        chk("after_reset_running", b4.RUNNING, 0);
        check_model();

        // Random pulses, frequent clears
        for (int i = 0; i < 2000; i++) begin
            cyc4($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 11) == 0);
            check_model();
        end
        // Random pulses, long runs reaching seconds
        for (int i = 0; i < 4000; i++) begin
            cyc4($urandom_range(0, 59) == 0, $urandom_range(0, 499) == 0,
                 $urandom_range(0, 29) == 0);
            check_model();
        end

        // DIV=1, MAX_MIN=2: full wrap with overflow pulse
        RSTn = 1'b0;
        #2;
        RSTn = 1'b1;
        mreset();
        cyc1(1);
        chk("w_running", b1.RUNNING, 1);
        chk("w_start_cs", b1.CS, 0);
        repeat (11998) cyc1(0);
        chk("w_pre_cs", b1.CS, 98);
        chk("w_pre_ovf", b1.OVF, 0);
        cyc1(0);
        chk("w_max", {b1.MIN, b1.SEC, b1.CS}, {1'b1, 6'd59, 7'd99});
        chk("w_ovf_high", b1.OVF, 1);
        cyc1(0);
        chk("w_zero", {b1.MIN, b1.SEC, b1.CS}, 0);
        chk("w_ovf_low", b1.OVF, 0);
        chk("w_still_running", b1.RUNNING, 1);
        cyc1(0);
        chk("w_continue_cs", b1.CS, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
